// File: rtl/seg_scan_ctrl.sv
// Scan controller for a 4-digit 7-segment display: digit select, blanked anode
// enables and a segment pattern that only changes between frames.
module seg_scan_ctrl #(
    parameter int          DIGIT_CYCLES  = 100000,
    parameter int          BLANK_CYCLES  = 1000,
    parameter bit          AN_ACTIVE_LOW = 1'b1,
    parameter logic [31:0] RESET_HEXS    = 32'hFFFF_FFFF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [31:0] disp_data,
    input  logic        data_valid,
    output logic [31:0] Hexs_out,
    output logic [2:0]  Scan,
    output logic [3:0]  AN,
    output logic        frame_done,
    output logic        busy
);

    localparam int             CNT_W     = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DIGIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYCLES);
    localparam logic [3:0]       AN_OFF    = AN_ACTIVE_LOW ? 4'b1111 : 4'b0000;

    logic [CNT_W-1:0] cnt_r;
    logic [1:0]       scan_r;
    logic [3:0]       an_r;
    logic [31:0]      hexs_r;
    logic [31:0]      pend_data_r;
    logic             pend_r;
    logic             frame_done_r;

    logic [CNT_W-1:0] cnt_nxt_s;
    logic [1:0]       scan_nxt_s;
    logic [3:0]       an_nxt_s;
    logic [3:0]       an_onehot_s;
    logic [31:0]      hexs_nxt_s;
    logic [31:0]      pend_data_nxt_s;
    logic             pend_nxt_s;
    logic             tick_s;
    logic             boundary_s;

    // Next-state for prescaler, digit select and anode enables.
    always_comb begin
        tick_s      = en && (cnt_r == CNT_LAST);
        boundary_s  = tick_s && (scan_r == 2'd3);
        cnt_nxt_s   = cnt_r;
        scan_nxt_s  = scan_r;
        an_nxt_s    = AN_OFF;
        an_onehot_s = 4'b0001 << scan_nxt_s;

        if (!en) begin
            cnt_nxt_s = '0;
        end else if (tick_s) begin
            cnt_nxt_s  = '0;
            scan_nxt_s = scan_r + 2'd1;
        end else begin
            cnt_nxt_s = cnt_r + CNT_ONE;
        end

        // AN is computed from the post-edge count and digit so it never lags Scan.
        an_onehot_s = 4'b0001 << scan_nxt_s;
        if (!en) begin
            an_nxt_s = AN_OFF;
        end else if (cnt_nxt_s < BLANK_END) begin
            an_nxt_s = AN_OFF;
        end else begin
            an_nxt_s = AN_ACTIVE_LOW ? ~an_onehot_s : an_onehot_s;
        end
    end

    // Next-state for the pending buffer and the frame-stable pattern.
    always_comb begin
        hexs_nxt_s      = hexs_r;
        pend_data_nxt_s = pend_data_r;
        pend_nxt_s      = pend_r;

        if (!en) begin
            // Display is dark: nothing can tear, so commit immediately.
            if (data_valid) begin
                hexs_nxt_s = disp_data;
                pend_nxt_s = 1'b0;
            end else if (pend_r) begin
                hexs_nxt_s = pend_data_r;
                pend_nxt_s = 1'b0;
            end else begin
                pend_nxt_s = 1'b0;
            end
        end else if (boundary_s) begin
            if (data_valid) begin
                hexs_nxt_s = disp_data;
            end else if (pend_r) begin
                hexs_nxt_s = pend_data_r;
            end else begin
                hexs_nxt_s = hexs_r;
            end
            pend_nxt_s = 1'b0;
        end else if (data_valid) begin
            pend_data_nxt_s = disp_data;
            pend_nxt_s      = 1'b1;
        end else begin
            pend_nxt_s = pend_r;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r        <= '0;
            scan_r       <= 2'd0;
            an_r         <= AN_OFF;
            hexs_r       <= RESET_HEXS;
            pend_data_r  <= 32'h0000_0000;
            pend_r       <= 1'b0;
            frame_done_r <= 1'b0;
        end else begin
            cnt_r        <= cnt_nxt_s;
            scan_r       <= scan_nxt_s;
            an_r         <= an_nxt_s;
            hexs_r       <= hexs_nxt_s;
            pend_data_r  <= pend_data_nxt_s;
            pend_r       <= pend_nxt_s;
            frame_done_r <= boundary_s;
        end
    end

    assign Hexs_out   = hexs_r;
    assign Scan       = {1'b0, scan_r};
    assign AN         = an_r;
    assign frame_done = frame_done_r;
    assign busy       = pend_r;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl: startup vector table, directed data
// commit sequences, randomized run against a slot/tick reference model.
module tb_seg_scan_ctrl;

    localparam int D = 8;
    localparam int B = 2;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic [31:0] disp_data;
    logic        data_valid;
    logic [31:0] Hexs_out;
    logic [2:0]  Scan;
    logic [3:0]  AN;
    logic        frame_done;
    logic        busy;

    int n_pass;
    int n_total;

    // reference model: position inside the slot and number of slot ticks so far
    int          m_age;
    int          m_ticks;
    logic        m_en;
    logic [31:0] m_hexs;
    logic        m_pend;
    logic [31:0] m_pd;
    logic        m_fd;

    typedef struct {
        logic       e;
        logic       v;
        logic [2:0] scan;
        logic [3:0] an;
        logic       fd;
    } vec_t;
    vec_t tbl[40];

    seg_scan_ctrl #(
        .DIGIT_CYCLES (D),
        .BLANK_CYCLES (B),
        .AN_ACTIVE_LOW(1'b1),
        .RESET_HEXS   (32'hFFFF_FFFF)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .disp_data (disp_data),
        .data_valid(data_valid),
        .Hexs_out  (Hexs_out),
        .Scan      (Scan),
        .AN        (AN),
        .frame_done(frame_done),
        .busy      (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_age = 0; m_ticks = 0; m_en = 1'b0;
        m_hexs = 32'hFFFF_FFFF; m_pend = 1'b0; m_pd = 32'h0; m_fd = 1'b0;
    endtask

    task automatic model_edge(input logic e, input logic v, input logic [31:0] d);
        logic wrap, bnd;
        m_en = e;
        if (e) begin
            wrap = (m_age == D - 1);
            bnd  = wrap && (m_ticks % 4 == 3);
            if (wrap) begin
                m_age = 0;
                m_ticks++;
            end else begin
                m_age++;
            end
            m_fd = bnd;
            if (bnd) begin
                if (v) m_hexs = d;
                else if (m_pend) m_hexs = m_pd;
                m_pend = 1'b0;
            end else if (v) begin
                m_pd = d;
                m_pend = 1'b1;
            end
        end else begin
            m_age = 0;
            m_fd  = 1'b0;
            if (v) m_hexs = d;
            else if (m_pend) m_hexs = m_pd;
            m_pend = 1'b0;
        end
    endtask

    function automatic logic [3:0] m_an();
        if (!m_en || m_age < B) return 4'hF;
        return (~(4'b0001 << (m_ticks % 4))) & 4'hF;
    endfunction

    task automatic step(input logic e, input logic v, input logic [31:0] d);
        en = e; data_valid = v; disp_data = d;
        @(posedge clk);
        model_edge(e, v, d);
        #1;
        chk("scan", 32'(Scan), 32'(m_ticks % 4));
        chk("an", 32'(AN), 32'(m_an()));
        chk("hexs", Hexs_out, m_hexs);
        chk("busy", 32'(busy), 32'(m_pend));
        chk("frame_done", 32'(frame_done), 32'(m_fd));
    endtask

    task automatic wait_frame(input string name);
        logic found;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            step(1'b1, 1'b0, 32'h0);
            if (frame_done) found = 1'b1;
        end
        chk(name, 32'(found), 32'd1);
    endtask

    initial begin
        logic [1:0] s_hold;
        n_pass = 0; n_total = 0;
        rst_n = 1'b0; en = 1'b0; data_valid = 1'b0; disp_data = 32'h0;
        model_reset();

        // closed-form startup table: n edges after release
        for (int k = 0; k < 40; k++) begin
            int n, c, s;
            n = k + 1; c = n % D; s = (n / D) % 4;
            tbl[k].e    = 1'b1;
            tbl[k].v    = 1'b0;
            tbl[k].scan = 3'(s);
            tbl[k].an   = (c < B) ? 4'hF : (~(4'b0001 << s)) & 4'hF;
            tbl[k].fd   = (n % 32 == 0);
        end

        #12;
        chk("rst_hexs", Hexs_out, 32'hFFFF_FFFF);
        chk("rst_scan", 32'(Scan), 32'd0);
        chk("rst_an", 32'(AN), 32'hF);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_fd", 32'(frame_done), 32'd0);
        en = 1'b1;
        rst_n = 1'b1;

        for (int k = 0; k < 40; k++) begin
            step(tbl[k].e, tbl[k].v, 32'h0);
            chk("tbl_scan", 32'(Scan), 32'(tbl[k].scan));
            chk("tbl_an", 32'(AN), 32'(tbl[k].an));
            chk("tbl_fd", 32'(frame_done), 32'(tbl[k].fd));
        end

        // single pending write in slot 1, committed at the frame boundary
        step(1'b1, 1'b1, 32'h1234_5678);
        chk("pend_busy", 32'(busy), 32'd1);
        chk("pend_hold", Hexs_out, 32'hFFFF_FFFF);
        step(1'b1, 1'b0, 32'h0);
        chk("pend_hold2", Hexs_out, 32'hFFFF_FFFF);
        wait_frame("wait_fd1");
        chk("commit1", Hexs_out, 32'h1234_5678);
        chk("commit1_busy", 32'(busy), 32'd0);

        // last of two writes wins
        step(1'b1, 1'b1, 32'hAAAA_0000);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 32'h0);
        step(1'b1, 1'b1, 32'h0000_BBBB);
        chk("lastwins_hold", Hexs_out, 32'h1234_5678);
        wait_frame("wait_fd2");
        chk("lastwins", Hexs_out, 32'h0000_BBBB);

        // write exactly on the boundary edge
        for (int i = 0; i < 40 && !(m_age == D - 1 && m_ticks % 4 == 3); i++)
            step(1'b1, 1'b0, 32'h0);
        step(1'b1, 1'b1, 32'hCAFE_F00D);
        chk("bnd_hexs", Hexs_out, 32'hCAFE_F00D);
        chk("bnd_busy", 32'(busy), 32'd0);
        chk("bnd_fd", 32'(frame_done), 32'd1);

        // drop en mid-slot
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 32'h0);
        s_hold = 2'(m_ticks % 4);
        step(1'b0, 1'b0, 32'h0);
        chk("dark_an", 32'(AN), 32'hF);
        chk("dark_scan", 32'(Scan), 32'(s_hold));
        step(1'b0, 1'b1, 32'h5A5A_5A5A);
        chk("dark_commit", Hexs_out, 32'h5A5A_5A5A);
        step(1'b1, 1'b1, 32'h1111_2222);
        chk("reen_blank", 32'(AN), 32'hF);
        chk("reen_busy", 32'(busy), 32'd1);
        step(1'b0, 1'b0, 32'h0);
        chk("dark_flush", Hexs_out, 32'h1111_2222);
        chk("dark_flush_busy", 32'(busy), 32'd0);
        step(1'b1, 1'b0, 32'h0);
        chk("restart_blank", 32'(AN), 32'hF);
        step(1'b1, 1'b0, 32'h0);
        chk("restart_on", 32'(AN), 32'((~(4'b0001 << s_hold)) & 4'hF));
        chk("restart_scan", 32'(Scan), 32'(s_hold));

        // randomized traffic against the model
        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 9) != 0, $urandom_range(0, 7) == 0, $urandom);

        // asynchronous reset while a write is pending
        step(1'b1, 1'b0, 32'h0);
        if (m_age == D - 1) step(1'b1, 1'b0, 32'h0);
        step(1'b1, 1'b1, 32'hDEAD_BEEF);
        chk("pre_rst_busy", 32'(busy), 32'd1);
        data_valid = 1'b0;
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_hexs", Hexs_out, 32'hFFFF_FFFF);
        chk("arst_scan", 32'(Scan), 32'd0);
        chk("arst_an", 32'(AN), 32'hF);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_fd", 32'(frame_done), 32'd0);
        @(negedge clk);
        model_reset();
        rst_n = 1'b1;
        for (int i = 0; i < 40; i++) step(1'b1, 1'b0, 32'h0);
        chk("discarded", Hexs_out, 32'hFFFF_FFFF);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
